// File: rtl/rst_pulse_ctrl.sv
// Multi-channel self-timed peripheral reset pulse generator behind the AXI-lite register decode.
// Optional HOLD register (word 4) is built when RST_PULSE_HOLD_EN is defined.
module rst_pulse_ctrl #(
    parameter int unsigned NUM_CH      = 16,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_LEN = 4,
    parameter int unsigned SELF_CH     = 12,
    parameter int unsigned ADDR_W      = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [7:0]        reglk_ctrl_i,
    input  logic              acct_ctrl_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [63:0]       wdata_i,
    output logic [63:0]       rdata_o,
    output logic [NUM_CH-1:0] rst_o,
    output logic              busy_o
);

    localparam logic [5:0] AddrTrigger = 6'd0;
    localparam logic [5:0] AddrLen     = 6'd1;
    localparam logic [5:0] AddrMask    = 6'd2;
    localparam logic [5:0] AddrStatus  = 6'd3;
    localparam logic [5:0] AddrHold    = 6'd4;

    typedef enum logic {StIdle, StActive} ch_state_e;

    ch_state_e          state_q [NUM_CH];
    logic [CNT_W-1:0]   cnt_q   [NUM_CH];
    logic [NUM_CH-1:0]  pulse_q;
    logic [CNT_W-1:0]   pulse_len_q;
    logic [NUM_CH-1:0]  en_mask_q;
    logic [NUM_CH-1:0]  hold;

    logic               access;
    logic               wr_en;
    logic [5:0]         word;
    logic [NUM_CH-1:0]  trig_mask;
    logic               self_rst;
    logic [CNT_W-1:0]   load_len;

    assign access    = en_i & acct_ctrl_i;
    assign wr_en     = access & we_i & ~reglk_ctrl_i[1];
    assign word      = address_i[8:3];
    assign trig_mask = (wr_en && word == AddrTrigger) ? (wdata_i[NUM_CH-1:0] & en_mask_q) : '0;
    // A self-reset request wins over every other bit of the same trigger write.
    assign self_rst  = trig_mask[SELF_CH];
    assign load_len  = (pulse_len_q == '0) ? CNT_W'(1) : pulse_len_q;

`ifdef RST_PULSE_HOLD_EN
    localparam logic [NUM_CH-1:0] SelfBit = NUM_CH'(1) << SELF_CH;
    logic [NUM_CH-1:0] hold_q;
    assign hold = hold_q;
`else
    assign hold = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pulse_len_q <= CNT_W'(DEFAULT_LEN);
            en_mask_q   <= '1;
            pulse_q     <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
`ifdef RST_PULSE_HOLD_EN
            hold_q      <= '0;
`endif
        end else if (self_rst) begin
            pulse_len_q <= CNT_W'(DEFAULT_LEN);
            en_mask_q   <= '1;
            pulse_q     <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
`ifdef RST_PULSE_HOLD_EN
            hold_q      <= '0;
`endif
        end else begin
            if (wr_en && word == AddrLen) begin
                pulse_len_q <= wdata_i[CNT_W-1:0];
            end
            if (wr_en && word == AddrMask) begin
                en_mask_q <= wdata_i[NUM_CH-1:0];
            end
`ifdef RST_PULSE_HOLD_EN
            if (wr_en && word == AddrHold) begin
                hold_q <= wdata_i[NUM_CH-1:0] & ~SelfBit;
            end
`endif
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (i != SELF_CH && trig_mask[i]) begin
                    // Load and retrigger share one path, so a reload never drops the line.
                    state_q[i] <= StActive;
                    cnt_q[i]   <= load_len;
                    pulse_q[i] <= 1'b1;
                end else begin
                    case (state_q[i])
                        StActive: begin
                            if (cnt_q[i] <= CNT_W'(1)) begin
                                state_q[i] <= StIdle;
                                cnt_q[i]   <= '0;
                                pulse_q[i] <= 1'b0;
                            end else begin
                                cnt_q[i]   <= cnt_q[i] - CNT_W'(1);
                                pulse_q[i] <= 1'b1;
                            end
                        end
                        default: begin
                            state_q[i] <= StIdle;
                            cnt_q[i]   <= '0;
                            pulse_q[i] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign rst_o  = pulse_q | hold;
    assign busy_o = |rst_o;

    always_comb begin
        rdata_o = '0;
        if (access && !reglk_ctrl_i[0]) begin
            case (word)
                AddrLen:    rdata_o = 64'(pulse_len_q);
                AddrMask:   rdata_o = 64'(en_mask_q);
                AddrStatus: rdata_o = 64'(rst_o);
`ifdef RST_PULSE_HOLD_EN
                AddrHold:   rdata_o = 64'(hold_q);
`endif
                default:    rdata_o = '0;
            endcase
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{address_i[ADDR_W-1:9], address_i[2:0], wdata_i[63:NUM_CH],
                             reglk_ctrl_i[7:2]};

endmodule

// File: tb/tb_rst_pulse_ctrl.sv
// Randomized self-checking bench for rst_pulse_ctrl against an end-cycle based reference model.
// Define RST_PULSE_HOLD_EN for both files to cover the HOLD register.
module tb_rst_pulse_ctrl;

    localparam int NCH     = 16;
    localparam int SELF    = 12;
    localparam int DEF_LEN = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  reglk_ctrl_i;
    logic        acct_ctrl_i;
    logic        en_i;
    logic        we_i;
    logic [63:0] address_i;
    logic [63:0] wdata_i;
    logic [63:0] rdata_o;
    logic [15:0] rst_o;
    logic        busy_o;

    rst_pulse_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .reglk_ctrl_i (reglk_ctrl_i),
        .acct_ctrl_i  (acct_ctrl_i),
        .en_i         (en_i),
        .we_i         (we_i),
        .address_i    (address_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .rst_o        (rst_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: each channel's pulse is the closed cycle range ending at end_c[i].
    longint      cyc;
    longint      end_c [NCH];
    logic [7:0]  m_len;
    logic [15:0] m_mask;
    logic [15:0] m_hold;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_len  = 8'(DEF_LEN);
        m_mask = 16'hFFFF;
        m_hold = 16'h0;
        for (int i = 0; i < NCH; i++) end_c[i] = -1;
    endtask

    function automatic logic [15:0] exp_rst();
        logic [15:0] r;
        for (int i = 0; i < NCH; i++) r[i] = (cyc <= end_c[i]) | m_hold[i];
        return r;
    endfunction

    function automatic logic [63:0] exp_rdata();
        if (!(en_i && acct_ctrl_i) || reglk_ctrl_i[0]) return 64'h0;
        case (address_i[8:3])
            6'd1:    return 64'(m_len);
            6'd2:    return 64'(m_mask);
            6'd3:    return 64'(exp_rst());
`ifdef RST_PULSE_HOLD_EN
            6'd4:    return 64'(m_hold);
`endif
            default: return 64'h0;
        endcase
    endfunction

    // Applies the bus access sampled at the edge that just happened.
    task automatic model_edge();
        logic [15:0] trig;
        longint      len;
        cyc++;
        if (en_i && acct_ctrl_i && we_i && !reglk_ctrl_i[1]) begin
            case (address_i[8:3])
                6'd0: begin
                    trig = wdata_i[15:0] & m_mask;
                    if (trig[SELF]) begin
                        model_reset();
                    end else begin
                        len = (m_len == 0) ? 1 : longint'(m_len);
                        for (int i = 0; i < NCH; i++)
                            if (trig[i]) end_c[i] = cyc + len - 1;
                    end
                end
                6'd1: m_len = wdata_i[7:0];
                6'd2: m_mask = wdata_i[15:0];
`ifdef RST_PULSE_HOLD_EN
                6'd4: m_hold = wdata_i[15:0] & ~(16'h1 << SELF);
`endif
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic en, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] lk, input logic acct);
        @(negedge clk_i);
        en_i = en; we_i = we; address_i = addr; wdata_i = wdata;
        reglk_ctrl_i = lk; acct_ctrl_i = acct;
        #1;
        check_eq("rdata", rdata_o, exp_rdata());
        @(posedge clk_i);
        model_edge();
        #1;
        check_eq("rst_o", 64'(rst_o), 64'(exp_rst()));
        check_eq("busy_o", 64'(busy_o), 64'(|exp_rst()));
    endtask

    function automatic logic [63:0] waddr(input int w);
        return 64'(w) << 3;
    endfunction

    task automatic wr(input int w, input logic [63:0] d);
        step(1'b1, 1'b1, waddr(w), d, 8'h00, 1'b1);
    endtask

    task automatic rd(input int w);
        step(1'b1, 1'b0, waddr(w), 64'h0, 8'h00, 1'b1);
    endtask

    int cnt_a;
    int cnt_b;

    initial begin
        rst_ni = 1'b0; en_i = 1'b0; we_i = 1'b0; address_i = '0; wdata_i = '0;
        reglk_ctrl_i = 8'h0; acct_ctrl_i = 1'b1;
        cyc = 0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_in_reset", 64'(rst_o), 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        rd(1); check_eq("reset_len", rdata_o, 64'd4);
        rd(2); check_eq("reset_mask", rdata_o, 64'hFFFF);
        rd(3); check_eq("reset_status", rdata_o, 64'h0);

        // Two channels, 3-cycle pulse.
        wr(1, 64'd3);
        wr(0, 64'h0006);
        cnt_a = int'(rst_o[1]); cnt_b = int'(rst_o[2]);
        for (int k = 0; k < 6; k++) begin
            rd(3);
            cnt_a += int'(rst_o[1]); cnt_b += int'(rst_o[2]);
        end
        check_eq("len3_ch1", 64'(cnt_a), 64'd3);
        check_eq("len3_ch2", 64'(cnt_b), 64'd3);

        // Zero length gives a single-cycle pulse.
        wr(1, 64'd0);
        wr(0, 64'h0020);
        cnt_a = int'(rst_o[5]);
        for (int k = 0; k < 4; k++) begin rd(3); cnt_a += int'(rst_o[5]); end
        check_eq("len0_ch5", 64'(cnt_a), 64'd1);

        // Retrigger during the pulse extends it without a gap.
        wr(1, 64'd10);
        wr(0, 64'h0080);
        cnt_a = int'(rst_o[7]);
        rd(3); cnt_a += int'(rst_o[7]);
        rd(3); cnt_a += int'(rst_o[7]);
        wr(0, 64'h0080); cnt_a += int'(rst_o[7]);
        for (int k = 0; k < 15; k++) begin rd(3); cnt_a += int'(rst_o[7]); end
        check_eq("retrig_ch7", 64'(cnt_a), 64'd13);

        // Masked channel ignored.
        wr(1, 64'd2);
        wr(2, 64'hFFFD);
        wr(0, 64'h0003);
        check_eq("mask_ch0", 64'(rst_o[1:0]), 64'h1);
        rd(3); rd(3);

        // Lock and access control.
        step(1'b1, 1'b1, waddr(1), 64'd9, 8'h02, 1'b1);
        rd(1); check_eq("lock_len", rdata_o, 64'd2);
        step(1'b1, 1'b0, waddr(2), 64'h0, 8'h01, 1'b1);
        check_eq("rdlock", rdata_o, 64'h0);
        step(1'b1, 1'b1, waddr(0), 64'h0001, 8'h00, 1'b0);
        check_eq("acct_trig", 64'(rst_o), 64'h0);
        wr(2, 64'hFFFF);

        // Self-reset while another channel is running.
        wr(1, 64'd20);
        wr(0, 64'h0008);
        rd(3); rd(3);
        wr(0, 64'h1001);
        check_eq("self_rst_o", 64'(rst_o), 64'h0);
        cnt_a = int'(rst_o[0]) + int'(rst_o[SELF]);
        rd(1); check_eq("self_len", rdata_o, 64'd4);
        rd(2); check_eq("self_mask", rdata_o, 64'hFFFF);
        for (int k = 0; k < 4; k++) begin rd(3); cnt_a += int'(rst_o[0]) + int'(rst_o[SELF]); end
        check_eq("self_quiet", 64'(cnt_a), 64'd0);

        // HOLD register; reads 0 when not built.
        wr(4, 64'h0100);
        for (int k = 0; k < 5; k++) rd(4);
        wr(4, 64'h0000);
        rd(3);
        wr(4, 64'h1000);
        rd(4);
        check_eq("hold_self", rdata_o, 64'h0);
        wr(4, 64'h0000);

        // Randomized traffic.
        for (int k = 0; k < 800; k++) begin
            logic [63:0] a, d;
            logic [7:0]  lk;
            int          w;
            w = $urandom_range(0, 6);
            a = {$urandom, $urandom};
            a[8:3] = 6'(w);
            d = {$urandom, $urandom};
            if (w == 1 && $urandom_range(0, 3) != 0) d = 64'($urandom_range(0, 12));
            if (w == 0 && $urandom_range(0, 9) != 0) d[SELF] = 1'b0;
            lk = 8'($urandom);
            lk[1:0] = ($urandom_range(0, 7) == 0) ? lk[1:0] : 2'b00;
            step(($urandom_range(0, 3) != 0), 1'($urandom), a, d, lk,
                 ($urandom_range(0, 9) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
